// File: rtl/alu_serial_pkg.sv
// Shared definitions for the bit-serial ALU: slice operation codes, word-level
// control codes ({invertA, invertB, operation}) and FSM state encodings.
package alu_serial_pkg;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_LESS = 2'b11;

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_NOR = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } state_t;

    function automatic logic ctrl_inv_a(input logic [3:0] ctrl);
        return ctrl[3];
    endfunction

    function automatic logic ctrl_inv_b(input logic [3:0] ctrl);
        return ctrl[2];
    endfunction

endpackage

// File: rtl/alu_serial_if.sv
// Start/done request interface between datapath control (master) and the
// bit-serial ALU (slave).
interface alu_serial_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       alu_ctrl;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    logic             zero;

    modport master (
        output start, a, b, alu_ctrl,
        input  busy, done, result, cout, overflow, zero
    );

    modport slave (
        input  start, a, b, alu_ctrl,
        output busy, done, result, cout, overflow, zero
    );
endinterface

// File: rtl/alu_serial_slice.sv
// One-bit ALU slice: optional operand inversion, AND/OR/full-add/less mux,
// with the raw adder sum exposed so the MSB pass can derive the SLT set bit.
module alu_serial_slice
    import alu_serial_pkg::*;
(
    input  logic       i_a,
    input  logic       i_b,
    input  logic       i_inv_a,
    input  logic       i_inv_b,
    input  logic [1:0] i_op,
    input  logic       i_cin,
    input  logic       i_less,
    output logic       o_result,
    output logic       o_cout,
    output logic       o_sum
);
    logic w_a;
    logic w_b;

    assign w_a    = i_a ^ i_inv_a;
    assign w_b    = i_b ^ i_inv_b;
    assign o_sum  = w_a ^ w_b ^ i_cin;
    assign o_cout = (w_a & w_b) | (w_a & i_cin) | (w_b & i_cin);

    always_comb begin
        o_result = 1'b0;
        case (i_op)
            OP_AND:  o_result = w_a & w_b;
            OP_OR:   o_result = w_a | w_b;
            OP_ADD:  o_result = o_sum;
            OP_LESS: o_result = i_less;
            default: o_result = 1'b0;
        endcase
    end
endmodule

// File: rtl/alu_serial.sv
// Bit-serial word ALU: steps a single 1-bit slice across WIDTH bit positions,
// one bit per clock, with a trailing FIX cycle for set-less-than.
module alu_serial
    import alu_serial_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    alu_serial_if.slave  bus
);
    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [3:0]       r_ctrl;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic             r_set;
    logic [WIDTH-1:0] r_result;
    logic             r_busy;
    logic             r_done;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    logic             w_res;
    logic             w_cout;
    logic             w_sum;
    logic             w_ovf;
    logic             w_last;
    logic [1:0]       w_op;
    logic [WIDTH-1:0] w_shift;

    assign w_op    = r_ctrl[1:0];
    assign w_last  = (r_idx == IDX_LAST);
    assign w_ovf   = w_cout ^ r_carry;
    // Result fills from the MSB side so bit 0 lands at result[0] after WIDTH shifts.
    assign w_shift = {w_res, r_result[WIDTH-1:1]};

    alu_serial_slice u_slice (
        .i_a      (r_a[r_idx]),
        .i_b      (r_b[r_idx]),
        .i_inv_a  (ctrl_inv_a(r_ctrl)),
        .i_inv_b  (ctrl_inv_b(r_ctrl)),
        .i_op     (w_op),
        .i_cin    (r_carry),
        .i_less   (1'b0),
        .o_result (w_res),
        .o_cout   (w_cout),
        .o_sum    (w_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_ctrl   <= '0;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_set    <= 1'b0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_a      <= bus.a;
                        r_b      <= bus.b;
                        r_ctrl   <= bus.alu_ctrl;
                        r_idx    <= '0;
                        r_carry  <= ctrl_inv_b(bus.alu_ctrl);
                        r_result <= '0;
                        r_cout   <= 1'b0;
                        r_ovf    <= 1'b0;
                        r_zero   <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_result <= w_shift;
                    r_carry  <= w_cout;
                    r_idx    <= r_idx + IDX_W'(1);
                    if (w_last) begin
                        r_cout <= w_cout;
                        r_ovf  <= (w_op == OP_ADD) ? w_ovf : 1'b0;
                        // Overflow-corrected sign of a-b, used by SLT.
                        r_set  <= w_sum ^ w_ovf;
                        if (w_op == OP_LESS) begin
                            r_state <= ST_FIX;
                        end else begin
                            r_zero  <= (w_shift == '0);
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_FIX: begin
                    r_result <= {{(WIDTH-1){1'b0}}, r_set};
                    r_zero   <= ~r_set;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.result   = r_result;
    assign bus.cout     = r_cout;
    assign bus.overflow = r_ovf;
    assign bus.zero     = r_zero;
endmodule

// File: tb/tb_alu_serial.sv
// Scoreboard bench for alu_serial at WIDTH=8: directed requests push expected
// responses; a negedge monitor pops one per done pulse and compares.
module tb_alu_serial;
    import alu_serial_pkg::*;

    localparam int W = 8;

    typedef struct {
        string      name;
        logic [7:0] res;
        logic       c;
        logic       v;
        logic       z;
        int         lat;
        int         acc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    alu_serial_if #(.WIDTH(W)) bus ();

    alu_serial #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_result"}, 32'(bus.result), 32'(e.res));
                chk({e.name, "_cout"}, 32'(bus.cout), 32'(e.c));
                chk({e.name, "_ovf"}, 32'(bus.overflow), 32'(e.v));
                chk({e.name, "_zero"}, 32'(bus.zero), 32'(e.z));
                chk({e.name, "_busy_low"}, 32'(bus.busy), 32'd0);
                chk({e.name, "_latency"}, 32'(cyc - e.acc), 32'(e.lat));
            end
        end
    end

    // Called at a negedge; returns at the following negedge with start low.
    task automatic issue(input string name, input logic [7:0] ia, input logic [7:0] ib,
                         input logic [3:0] ctl, input logic push,
                         input logic [7:0] er, input logic ec, input logic ev, input logic ez);
        exp_t e;
        bus.a        = ia;
        bus.b        = ib;
        bus.alu_ctrl = ctl;
        bus.start    = 1'b1;
        if (push) begin
            e.name = name;
            e.res  = er;
            e.c    = ec;
            e.v    = ev;
            e.z    = ez;
            e.lat  = (ctl[1:0] == OP_LESS) ? W + 1 : W;
            e.acc  = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain_outstanding", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.alu_ctrl = '0;
        idle_cycles(3);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_flags", 32'({bus.cout, bus.overflow, bus.zero}), 32'd0);

        issue("add", 8'h7F, 8'h01, CTRL_ADD, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0);
        drain();
        issue("sub", 8'h05, 8'h05, CTRL_SUB, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
        drain();
        issue("slt_neg", 8'hFF, 8'h01, CTRL_SLT, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
        drain();
        issue("slt_ovf", 8'h7F, 8'h80, CTRL_SLT, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        drain();
        issue("nor", 8'hF0, 8'h0F, CTRL_NOR, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
        drain();
        issue("or", 8'hF0, 8'h0F, CTRL_OR, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        drain();
        issue("and", 8'hF0, 8'h3C, CTRL_AND, 1'b1, 8'h30, 1'b1, 1'b0, 1'b0);
        drain();

        // Start pulse during RUN must be dropped.
        issue("ign_first", 8'h10, 8'h20, CTRL_ADD, 1'b1, 8'h30, 1'b0, 1'b0, 1'b0);
        idle_cycles(2);
        issue("ign_extra", 8'hFF, 8'hFF, CTRL_NOR, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        drain();
        idle_cycles(12);

        // Start in the done cycle is accepted immediately.
        issue("b2b_a", 8'h01, 8'h02, CTRL_ADD, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
        begin
            int n = 0;
            while (!bus.done && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("b2b_done_seen", 32'(bus.done), 32'd1);
        end
        issue("b2b_b", 8'h03, 8'h05, CTRL_SUB, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
        chk("b2b_busy_rise", 32'(bus.busy), 32'd1);
        drain();

        // Reset on the 4th RUN edge aborts with no done.
        issue("rst_mid", 8'h11, 8'h22, CTRL_ADD, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        idle_cycles(3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        chk("rst_mid_done", 32'(bus.done), 32'd0);
        chk("rst_mid_result", 32'(bus.result), 32'd0);
        chk("rst_mid_flags", 32'({bus.cout, bus.overflow, bus.zero}), 32'd0);
        idle_cycles(12);

        issue("add_after_rst", 8'h40, 8'h40, CTRL_ADD, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
